boron_sbox_layer_seq: RTL and testbench
=======================================

// Module: boron_sbox_layer_seq
// PURPOSE
//  Iterative BORON S-box layer: substitutes every 4-bit nibble of a WIDTH-bit state,
//  using the forward S-box or the inverse S-box, selected per transaction.
//  LANES S-box instances run in parallel, so one state takes WIDTH/(4*LANES) cycles.
//  Sits between round-key XOR and permutation in the area-tunable BORON datapath.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  64  state width in bits; must be a multiple of 4
//  LANES  4   S-boxes per cycle; must divide WIDTH/4 (elaboration error otherwise)
//  Derived: N = WIDTH/(4*LANES), the number of RUN cycles per state; counter width = max(1,$clog2(N))
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      synchronous, active-low reset
//  in_valid  in   1      in_data/in_mode valid
//  in_ready  out  1      block can accept a state
//  in_data   in   WIDTH  state to substitute
//  in_mode   in   1      0 = forward S-box, 1 = inverse S-box
//  out_valid out  1      out_data valid
//  out_ready in   1      consumer accepts out_data
//  out_data  out  WIDTH  substituted state
//  busy      out  1      high in RUN or DONE
// BEHAVIOUR
//  Forward S, nibble 0..F -> E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
//  Inverse S, nibble 0..F -> A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B.
//  Reset (rst_n=0 at a clk edge):
//   - state = IDLE; counter = 0; data register = 0; mode register = 0
//   - in_ready = 1 after reset; out_valid = 0; out_data = 0; busy = 0
//   - A reset mid-RUN or mid-DONE aborts the transaction. No output is produced for it.
//  FSM:
//   - IDLE: in_ready = 1. On in_valid && in_ready, latch in_data and in_mode, clear the counter, go to RUN.
//   - RUN: each edge, substitute nibbles [cnt*LANES +: LANES]. Only the low LANES nibbles of the
//     rotating register are substituted; they are placed at the top and the register is rotated
//     right by 4*LANES. cnt increments each edge. On the edge where cnt == N-1, go to DONE.
//   - DONE: out_valid = 1 and out_data = register, which is fully substituted with nibble order
//     preserved. On out_ready, go to IDLE.
//  Latency and throughput:
//   - out_valid rises N edges after the accepting edge.
//   - in_ready is 0 in RUN and DONE; no overlap, so throughput is one state per N+2 cycles minimum.
//   - N == 1 (LANES = WIDTH/4) is legal: a single RUN cycle.
//  Stability rules:
//   - out_data is stable and out_valid stays high until out_ready; backpressure is unlimited.
//   - in_data and in_mode changes after acceptance have no effect.
//   - out_data holds its last value when out_valid = 0 (zero after reset).
//  Wrap-around: the counter never exceeds N-1 and is cleared on acceptance.
//  Simultaneous events:
//   - in_valid during RUN/DONE is ignored (not accepted).
//   - out_ready while out_valid = 0 has no effect.
// TESTING
//  1. WIDTH=64, LANES=4, mode=0, in=64'h0123456789ABCDEF -> out=64'hE4B179CAD20F8536;
//     out_valid rises exactly 4 edges after acceptance.
//  2. Same config, mode=1, in=64'hE4B179CAD20F8536 -> out=64'h0123456789ABCDEF
//     (round trip); then mode=1 on all-zero input -> 64'hAAAAAAAAAAAAAAAA.
//  3. Backpressure: hold out_ready=0 for 10 cycles after out_valid; out_data and out_valid stay
//     constant, in_ready stays 0, and a new in_valid is not accepted. Release -> IDLE next edge.
//  4. Reset mid-RUN (after 2 RUN edges): pull rst_n low for one edge -> out_valid=0, out_data=0,
//     in_ready=1, busy=0. A new transaction then completes correctly.
//  5. LANES=16 (N=1), mode=0, in=64'hFFFFFFFFFFFFFFFF -> 64'h6666666666666666, out_valid 1 edge
//     after acceptance. Also LANES=1 (N=16) on vector 1 gives the same result after 16 edges.
//  6. Back-to-back random stream (1000 states, random modes, random in_valid/out_ready)
//     vs. a reference model: no loss, no duplication, order preserved.

Source files
------------

// File: rtl/boron_sbox_layer_seq.sv
// Iterative BORON S-box layer: LANES forward/inverse S-boxes substitute a WIDTH-bit
// state over WIDTH/(4*LANES) cycles using a rotating register, valid/ready on both sides.
`timescale 1ns/1ps

module boron_sbox_layer_seq #(
    parameter int WIDTH = 64,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    localparam int N  = WIDTH / (4 * LANES);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = 4 * LANES;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if ((WIDTH % 4) != 0 || ((WIDTH / 4) % LANES) != 0) begin : g_bad_params
        $error("boron_sbox_layer_seq: LANES must divide WIDTH/4 and WIDTH must be a multiple of 4");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE and holds until out_ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  data_d;
    logic              mode_q;
    logic [SW-1:0]     sub_lanes;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              busy_q;

    function automatic logic [3:0] fwd_sbox(input logic [3:0] x);
        case (x)
            4'h0: fwd_sbox = 4'hE;  4'h1: fwd_sbox = 4'h4;
            4'h2: fwd_sbox = 4'hB;  4'h3: fwd_sbox = 4'h1;
            4'h4: fwd_sbox = 4'h7;  4'h5: fwd_sbox = 4'h9;
            4'h6: fwd_sbox = 4'hC;  4'h7: fwd_sbox = 4'hA;
            4'h8: fwd_sbox = 4'hD;  4'h9: fwd_sbox = 4'h2;
            4'hA: fwd_sbox = 4'h0;  4'hB: fwd_sbox = 4'hF;
            4'hC: fwd_sbox = 4'h8;  4'hD: fwd_sbox = 4'h5;
            4'hE: fwd_sbox = 4'h3;  default: fwd_sbox = 4'h6;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: inv_sbox = 4'hA;  4'h1: inv_sbox = 4'h3;
            4'h2: inv_sbox = 4'h9;  4'h3: inv_sbox = 4'hE;
            4'h4: inv_sbox = 4'h1;  4'h5: inv_sbox = 4'hD;
            4'h6: inv_sbox = 4'hF;  4'h7: inv_sbox = 4'h4;
            4'h8: inv_sbox = 4'hC;  4'h9: inv_sbox = 4'h5;
            4'hA: inv_sbox = 4'h7;  4'hB: inv_sbox = 4'h2;
            4'hC: inv_sbox = 4'h6;  4'hD: inv_sbox = 4'h8;
            4'hE: inv_sbox = 4'h0;  default: inv_sbox = 4'hB;
        endcase
    endfunction

    always_comb begin
        sub_lanes = '0;
        for (int l = 0; l < LANES; l++) begin
            sub_lanes[4*l +: 4] = mode_q ? inv_sbox(data_q[4*l +: 4]) : fwd_sbox(data_q[4*l +: 4]);
        end
    end

    // Substituted low nibbles go to the top; after N steps every nibble is back in place.
    if (N == 1) begin : g_single
        assign data_d = sub_lanes;
    end else begin : g_rotate
        assign data_d = {sub_lanes, data_q[WIDTH-1:SW]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        mode_q     <= in_mode;
                        cnt_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    data_q <= data_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= data_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_boron_sbox_layer_seq.sv
// Bench for boron_sbox_layer_seq: three lane configurations share stimulus, one is
// selected for observation; a negedge monitor scores every output transfer.
`timescale 1ns/1ps

module tb_boron_sbox_layer_seq;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_mode;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         rdy0, rdy1, rdy2, ov0, ov1, ov2, bz0, bz1, bz2;
    logic [W-1:0] od0, od1, od2;
    logic [1:0]   st0, st1, st2;

    logic [1:0]   sel;
    logic         in_ready_m, out_valid_m, busy_m;
    logic [W-1:0] out_data_m;

    int checks;
    int failures;
    int rx_cnt;
    logic stop;

    logic [W-1:0] exp_q[$];
    logic         hold_pend;
    logic [W-1:0] hold_data;

    logic [3:0] fwd_t [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                               4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
    logic [3:0] inv_t [16] = '{4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
                               4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB};

    typedef struct {
        logic         mode;
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    boron_sbox_layer_seq #(.WIDTH(64), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .busy(bz0), .dbg_state(st0)
    );

    boron_sbox_layer_seq #(.WIDTH(64), .LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .busy(bz1), .dbg_state(st1)
    );

    boron_sbox_layer_seq #(.WIDTH(64), .LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .in_mode(in_mode), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .busy(bz2), .dbg_state(st2)
    );

    always_comb begin
        in_ready_m  = rdy0;
        out_valid_m = ov0;
        out_data_m  = od0;
        busy_m      = bz0;
        case (sel)
            2'd1: begin in_ready_m = rdy1; out_valid_m = ov1; out_data_m = od1; busy_m = bz1; end
            2'd2: begin in_ready_m = rdy2; out_valid_m = ov2; out_data_m = od2; busy_m = bz2; end
            default: ;
        endcase
    end

    function automatic logic [W-1:0] sbox_ref(input logic [W-1:0] d, input logic m);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 4; i++) begin
            r[4*i +: 4] = m ? inv_t[d[4*i +: 4]] : fwd_t[d[4*i +: 4]];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: push the model result on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", {63'd0, out_valid_m}, 64'd1);
                chk("hold_data", out_data_m, hold_data);
            end
            hold_pend = out_valid_m && !out_ready;
            hold_data = out_data_m;
            if (in_valid && in_ready_m) exp_q.push_back(sbox_ref(in_data, in_mode));
            if (out_valid_m && out_ready) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %h expected none", out_data_m);
                end else begin
                    chk("scoreboard", out_data_m, exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic drive_in(input logic m, input logic [W-1:0] d);
        logic ok;
        ok = 1'b0;
        in_mode  = m;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready_m) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_mode  = ~m;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready=1");
        end
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid_m && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (!out_valid_m) chk("in_ready_low_run", {63'd0, in_ready_m}, 64'd0);
        end
    endtask

    task automatic run_vec(input logic m, input logic [W-1:0] d, input logic [W-1:0] e, input int lat);
        int edges;
        drive_in(m, d);
        wait_out(edges);
        chk("latency", edges, lat);
        chk("out_data", out_data_m, e);
        chk("busy_done", {63'd0, busy_m}, 64'd1);
        @(posedge clk);
        #1;
        chk("back_to_idle", {63'd0, in_ready_m}, 64'd1);
    endtask

    task automatic do_reset(input logic [1:0] s);
        rst_n = 1'b0;
        sel   = s;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int edges;
        int rx_before;
        logic [W-1:0] e1;

        checks    = 0;
        failures  = 0;
        rx_cnt    = 0;
        stop      = 1'b0;
        hold_pend = 1'b0;
        sel       = 2'd0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        vecs[0] = '{1'b0, 64'h0123456789ABCDEF, 64'hE4B179CAD20F8536};
        vecs[1] = '{1'b1, 64'hE4B179CAD20F8536, 64'h0123456789ABCDEF};
        vecs[2] = '{1'b1, 64'h0000000000000000, 64'hAAAAAAAAAAAAAAAA};
        vecs[3] = '{1'b0, 64'h0000000000000000, 64'hEEEEEEEEEEEEEEEE};
        vecs[4] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h6666666666666666};
        vecs[5] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hBBBBBBBBBBBBBBBB};
        vecs[6] = '{1'b1, 64'h6666666666666666, 64'hFFFFFFFFFFFFFFFF};

        do_reset(2'd0);
        chk("rst_in_ready", {63'd0, in_ready_m}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid_m}, 64'd0);
        chk("rst_out_data", out_data_m, 64'd0);
        chk("rst_busy", {63'd0, busy_m}, 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i].mode, vecs[i].din, vecs[i].dout, 4);

        // Backpressure: output must freeze and no new state may be taken.
        e1 = 64'hE4B179CAD20F8536;
        out_ready = 1'b0;
        drive_in(1'b0, 64'h0123456789ABCDEF);
        wait_out(edges);
        chk("bp_latency", edges, 4);
        in_valid = 1'b1;
        in_data  = 64'h1111111111111111;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", {63'd0, out_valid_m}, 64'd1);
            chk("bp_out_data", out_data_m, e1);
            chk("bp_in_ready", {63'd0, in_ready_m}, 64'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {63'd0, out_valid_m}, 64'd0);
        chk("bp_release_ready", {63'd0, in_ready_m}, 64'd1);
        chk("bp_hold_after", out_data_m, e1);

        // Reset after two RUN edges aborts the state with no output.
        drive_in(1'b1, 64'h5A5A5A5A5A5A5A5A);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_out_valid", {63'd0, out_valid_m}, 64'd0);
        chk("abort_out_data", out_data_m, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready_m}, 64'd1);
        chk("abort_busy", {63'd0, busy_m}, 64'd0);
        run_vec(1'b0, 64'h0123456789ABCDEF, e1, 4);

        do_reset(2'd1);
        run_vec(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h6666666666666666, 1);
        do_reset(2'd2);
        run_vec(1'b0, 64'h0123456789ABCDEF, e1, 16);
        do_reset(2'd0);

        rx_before = rx_cnt;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    drive_in(1'($urandom_range(0, 1)), {$urandom, $urandom});
                end
                for (int t = 0; t < 300 && (exp_q.size() != 0 || out_valid_m); t++) begin
                    @(posedge clk);
                    #1;
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        chk("stream_count", rx_cnt - rx_before, 1000);
        chk("stream_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
